// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift unit: op encoding, FSM states, stage index bounds.
package shift_pkg;

    localparam logic SHIFT_SLL = 1'b0;
    localparam logic SHIFT_SRA = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Stages run from offset 16 (idx 4) down to offset 1 (idx 0)
    localparam logic [2:0] STAGE_FIRST = 3'd4;
    localparam logic [2:0] STAGE_LAST  = 3'd0;

endpackage

// File: rtl/shift_stage_mux.sv
// Single shared shift stage: shifts by 2**idx (SLL zero fill / SRA sign fill) when en, else passthrough.
module shift_stage_mux
    import shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data,
    input  logic [2:0]       idx,
    input  logic             op,
    input  logic             en,
    output logic [WIDTH-1:0] shifted
);

    logic [5:0]       amt;
    logic [WIDTH-1:0] sll;
    logic [WIDTH-1:0] sra;

    always_comb begin
        amt = 6'd1 << idx;
        sll = data << amt;
        sra = WIDTH'($signed(data) >>> amt);
        if (!en)
            shifted = data;
        else if (op == SHIFT_SRA)
            shifted = sra;
        else
            shifted = sll;
    end

endmodule

// File: rtl/multicycle_shift_ctrl.sv
// Iterative 32-bit SLL/SRA unit: one shared stage walked through offsets 16,8,4,2,1,
// fixed latency regardless of shift amount, start/done handshake to the sequencer.
module multicycle_shift_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_start,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic               in_op,
    output logic               out_busy,
    output logic               out_done,
    output logic [WIDTH-1:0]   out_result
);

    state_t             state;
    state_t             state_nxt;
    logic [2:0]         idx;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] shamt_q;
    logic               op_q;
    logic [WIDTH-1:0]   stage_out;

    shift_stage_mux #(.WIDTH(WIDTH)) u_stage (
        .data    (work),
        .idx     (idx),
        .op      (op_q),
        .en      (shamt_q[idx]),
        .shifted (stage_out)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (in_start) state_nxt = ST_SHIFT;
            ST_SHIFT: if (idx == STAGE_LAST) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            idx        <= STAGE_FIRST;
            work       <= '0;
            shamt_q    <= '0;
            op_q       <= SHIFT_SLL;
            out_result <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (in_start) begin
                        work    <= in_data;
                        shamt_q <= in_shamt;
                        op_q    <= in_op;
                        idx     <= STAGE_FIRST;
                    end
                end
                ST_SHIFT: begin
                    work <= stage_out;
                    // Last stage result goes straight to the output; it is held until the next op finishes
                    if (idx == STAGE_LAST)
                        out_result <= stage_out;
                    else
                        idx <= idx - 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign out_busy = (state != ST_IDLE);
    assign out_done = (state == ST_DONE);

endmodule

// File: tb/tb_multicycle_shift_ctrl.sv
// Scoreboard bench for multicycle_shift_ctrl: accepts modelled from the handshake rules,
// results from plain <</>>> arithmetic, checked by an independent negedge monitor.
module tb_multicycle_shift_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_start;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic        in_op;
    logic        out_busy;
    logic        out_done;
    logic [31:0] out_result;

    multicycle_shift_ctrl #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_start   (in_start),
        .in_data    (in_data),
        .in_shamt   (in_shamt),
        .in_op      (in_op),
        .out_busy   (out_busy),
        .out_done   (out_done),
        .out_result (out_result)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          errors   = 0;
    int          checks   = 0;
    int          cyc      = 0;
    int          busy_cnt = 0;
    int          done_cnt = 0;
    logic        mon_en   = 1'b0;
    logic        last_rst = 1'b0;
    logic [31:0] held     = '0;
    logic [31:0] last_res = '0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] ref_shift(logic [31:0] d, logic [4:0] s, logic op);
        if (op) return 32'($signed(d) >>> s);
        return d << s;
    endfunction

    // Reference model: idle unless within 6 cycles of an accept; an accept's result is due 6 edges later
    always @(posedge clock) begin
        cyc      <= cyc + 1;
        last_rst <= reset;
        if (reset) begin
            busy_cnt <= 0;
            q.delete();
            mon_en   <= 1'b1;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end else if (in_start) begin
            q.push_back('{ref_shift(in_data, in_shamt, in_op), cyc + 6});
            busy_cnt <= 6;
        end
    end

    always @(negedge clock) begin
        if (mon_en) begin
            chk("busy", {31'd0, out_busy}, {31'd0, busy_cnt != 0});
            chk("done", {31'd0, out_done}, {31'd0, busy_cnt == 1});
            if (out_done) begin
                done_cnt <= done_cnt + 1;
                last_res <= out_result;
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("result", out_result, e.res);
                    chk("latency", 32'(cyc), 32'(e.cyc));
                    held <= e.res;
                end
            end else if (last_rst) begin
                chk("reset_result", out_result, 32'd0);
                held <= '0;
            end else begin
                chk("result_hold", out_result, held);
            end
            if (q.size() != 0 && q[0].cyc < cyc) begin
                chk("missed_done", 32'(cyc), 32'(q[0].cyc));
                void'(q.pop_front());
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic issue(logic [31:0] d, logic [4:0] s, logic op);
        in_start = 1'b1;
        in_data  = d;
        in_shamt = s;
        in_op    = op;
        step(1);
        in_start = 1'b0;
        in_data  = $urandom;
        in_shamt = 5'($urandom_range(0, 31));
        in_op    = 1'($urandom_range(0, 1));
        step(6);
    endtask

    int d0;

    initial begin
        reset    = 1'b1;
        in_start = 1'b0;
        in_data  = '0;
        in_shamt = '0;
        in_op    = 1'b0;
        step(2);
        reset = 1'b0;
        step(1);

        issue(32'h0000_0001, 5'd31, 1'b0);
        chk("sll_31", last_res, 32'h8000_0000);
        issue(32'h8000_0000, 5'd4, 1'b1);
        chk("sra_neg_4", last_res, 32'hF800_0000);
        issue(32'h7FFF_FFF0, 5'd4, 1'b1);
        chk("sra_pos_4", last_res, 32'h07FF_FFFF);
        issue(32'h8000_0000, 5'd31, 1'b1);
        chk("sra_31", last_res, 32'hFFFF_FFFF);
        issue(32'hDEAD_BEEF, 5'd0, 1'b0);
        chk("shamt_0", last_res, 32'hDEAD_BEEF);

        // start pulses during SHIFT and DONE must be ignored
        d0 = done_cnt;
        in_start = 1'b1; in_data = 32'h1; in_shamt = 5'd1; in_op = 1'b0;
        step(1);
        in_start = 1'b0;
        step(1);
        in_start = 1'b1; in_data = 32'hFFFF_FFFF; in_shamt = 5'd8;
        step(1);
        in_start = 1'b0;
        step(3);
        in_start = 1'b1;
        step(1);
        in_start = 1'b0;
        step(8);
        chk("ignored_start_result", last_res, 32'h0000_0002);
        chk("ignored_start_dones", 32'(done_cnt - d0), 32'd1);

        // reset on the third SHIFT cycle aborts with no done
        d0 = done_cnt;
        in_start = 1'b1; in_data = 32'h8000_0000; in_shamt = 5'd8; in_op = 1'b1;
        step(1);
        in_start = 1'b0;
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(8);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        issue(32'h1234_5678, 5'd4, 1'b0);
        chk("after_abort", last_res, 32'h2345_6780);

        // start held high: one accept every 7 cycles
        d0 = done_cnt;
        in_start = 1'b1;
        for (int i = 0; i < 70; i++) begin
            in_data  = $urandom;
            in_shamt = 5'($urandom_range(0, 31));
            in_op    = 1'($urandom_range(0, 1));
            step(1);
        end
        in_start = 1'b0;
        step(10);
        chk("back_to_back_dones", 32'(done_cnt - d0), 32'd10);

        for (int i = 0; i < 20; i++)
            issue($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        step(2);

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
